wb_stage: RTL
=============

# wb_stage

Registered, parametrised writeback stage that sits between the execute/memory/CSR units and the register file / commit logic. It merges N prioritised write sources into a single rd write, buffers up to two completed instructions in an in-order skid buffer with valid/ready handshakes on both sides, and optionally exposes a forwarding lookup into the buffered results. It replaces the pass-through writeback wiring with a real pipeline boundary, so the register-file/commit side can stall without losing results.

## Interface
- `DATA_W`, 64, register data width.
- `ADDR_W`, 5, register index width.
- `NSRC`, 3, number of write sources; index 0 has highest priority (CSR=0, MEM=1, EX=2 in the core).
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `in_valid_i`  in  1  an instruction is presented.
- `in_ready_o`  out  1  stage can accept this cycle.
- `pc_i`  in  64  instruction PC, carried through for commit.
- `rd_i`  in  ADDR_W  destination register.
- `src_wen_i`  in  NSRC  per-source write enable.
- `src_wdata_i`  in  NSRC*DATA_W  per-source data; source k at bits [k*DATA_W +: DATA_W].
- `flush_i`  in  1  discard all buffered entries.
- `out_valid_o`  out  1  head entry valid.
- `out_ready_i`  in  1  consumer takes head entry.
- `pc_o`  out  64  head PC.
- `rd_o`  out  ADDR_W  head rd.
- `rd_wen_o`  out  1  head write enable.
- `rd_wdata_o`  out  DATA_W  head write data.
- `multi_src_o`  out  1  sticky: an accepted instruction had more than one source enabled.
- `fwd_rs_i`  in  ADDR_W  forwarding lookup index.
- `fwd_hit_o`  out  1  lookup matched a buffered write.
- `fwd_data_o`  out  DATA_W  matching data.

## Operation
- Accept when `in_valid_i && in_ready_o && !flush_i`.
- Merge at accept: wen = OR of `src_wen_i`; wdata = data of lowest-index enabled source; 0 if none.
- x0 suppression: if `rd_i == 0`, stored wen = 0 and wdata = 0.
- Multiple enabled sources: lowest index wins; `multi_src_o` sets and stays 1 until `rst`.
- Buffer: 2-entry FIFO, in-order; head drives all `*_o` commit outputs. Count 0..2.
- Pop when `out_valid_o && out_ready_i`. Push and pop in the same cycle allowed at count 1 (count stays 1); at count 0 the new entry appears next cycle, not same-cycle.
- `in_ready_o = (count < 2)`, from registered state only; no combinational path from `out_ready_i`.
- `flush_i`: next cycle count = 0; overrides push and pop in that cycle. `multi_src_o` unaffected.
- Forwarding: `fwd_hit_o` = 1 when `fwd_rs_i != 0` and some valid entry has wen=1 and rd == `fwd_rs_i`; `fwd_data_o` = youngest such entry's data, else 0. Combinational on registered state.
- Empty-slot outputs: when `out_valid_o` = 0, `pc_o`, `rd_o`, `rd_wen_o` and `rd_wdata_o` are 0.

## Timing
- Latency: accept in cycle T -> `out_valid_o` = 1 in T+1 (when empty, or if it is the next entry in order).
- Throughput: one instruction per cycle while `out_ready_i` = 1.
- Reset: count = 0; `out_valid_o` = 0, `in_ready_o` = 1 in the cycle after reset; all data outputs 0; `multi_src_o` = 0; `fwd_hit_o` = 0. Reset mid-operation drops entries without popping them.
- Full (count 2): `in_ready_o` = 0; a simultaneous pop frees a slot for the next cycle only.
- Head outputs are held stable while `out_valid_o && !out_ready_i`.

## Configuration
- `WB_FWD_EN` defined: forwarding lookup is implemented as described above.
- `WB_FWD_EN` undefined: `fwd_hit_o` and `fwd_data_o` are tied to 0, and no compare logic is generated. Ports remain, so instantiations are unchanged.

## Test plan
- Reset, then push rd=5 with src2 wen, data 0x11, and `out_ready_i` = 1 -> next cycle `out_valid_o` = 1, rd_o=5, rd_wdata_o=0x11; cycle after, `out_valid_o` = 0.
- Push with src0 (0xAA) and src2 (0xBB) both enabled, rd=3 -> rd_wdata_o=0xAA, `multi_src_o` = 1 and stays 1 through later traffic.
- Push with rd=0 and src1 data 0x55 -> rd_wen_o=0, rd_wdata_o=0; with `WB_FWD_EN`, `fwd_rs_i`=0 -> `fwd_hit_o`=0.
- Hold `out_ready_i` = 0 and push A (rd=7, 0x1) and B (rd=7, 0x2) -> `in_ready_o`=0 and head stays A; with `WB_FWD_EN`, `fwd_rs_i`=7 gives hit and 0x2; release -> A then B on consecutive cycles.
- At count 2, assert `flush_i` together with `in_valid_i` -> next cycle count 0, `out_valid_o`=0, and the flushed-cycle input is not stored.
- Stream 8 back-to-back pushes with `out_ready_i` = 1 -> 8 outputs in order, one per cycle, `in_ready_o` constantly 1.

Source files
------------

// File: rtl/wb_stage_if.sv
// Handshake/bus bundle for wb_stage: sources and instruction in, commit head and forwarding out.
interface wb_stage_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int NSRC   = 3
);
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [63:0]            pc_i;
    logic [ADDR_W-1:0]      rd_i;
    logic [NSRC-1:0]        src_wen_i;
    logic [NSRC*DATA_W-1:0] src_wdata_i;
    logic                   flush_i;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [63:0]            pc_o;
    logic [ADDR_W-1:0]      rd_o;
    logic                   rd_wen_o;
    logic [DATA_W-1:0]      rd_wdata_o;
    logic                   multi_src_o;
    logic [ADDR_W-1:0]      fwd_rs_i;
    logic                   fwd_hit_o;
    logic [DATA_W-1:0]      fwd_data_o;

    modport slave (
        input  in_valid_i, pc_i, rd_i, src_wen_i, src_wdata_i, flush_i,
        input  out_ready_i, fwd_rs_i,
        output in_ready_o, out_valid_o, pc_o, rd_o, rd_wen_o, rd_wdata_o,
        output multi_src_o, fwd_hit_o, fwd_data_o
    );

    modport master (
        output in_valid_i, pc_i, rd_i, src_wen_i, src_wdata_i, flush_i,
        output out_ready_i, fwd_rs_i,
        input  in_ready_o, out_valid_o, pc_o, rd_o, rd_wen_o, rd_wdata_o,
        input  multi_src_o, fwd_hit_o, fwd_data_o
    );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: priority merge of NSRC write sources into a 2-entry in-order skid buffer.
// Define WB_FWD_EN to build the forwarding lookup into buffered results.
module wb_stage #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int NSRC   = 3
) (
    input logic       clk,
    input logic       rst,
    wb_stage_if.slave bus
);
    logic [1:0]        r_count;
    logic              r_head;
    logic              r_multi;
    logic [63:0]       r_pc    [2];
    logic [ADDR_W-1:0] r_rd    [2];
    logic              r_wen   [2];
    logic [DATA_W-1:0] r_wdata [2];

    logic [DATA_W-1:0] w_src_data [NSRC];
    logic [DATA_W-1:0] w_merge_data;
    logic              w_any_wen;
    logic              w_multi;
    logic              w_rd_zero;
    logic              w_store_wen;
    logic [DATA_W-1:0] w_store_data;
    logic              w_out_valid;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_pop;
    logic              w_tail;

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            assign w_src_data[gi] = bus.src_wdata_i[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Scan from the lowest-priority source down so the lowest enabled index wins.
    always_comb begin
        w_merge_data = '0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            if (bus.src_wen_i[k]) begin
                w_merge_data = w_src_data[k];
            end
        end
    end

    assign w_any_wen    = |bus.src_wen_i;
    assign w_multi      = (bus.src_wen_i & (bus.src_wen_i - NSRC'(1))) != '0;
    assign w_rd_zero    = (bus.rd_i == '0);
    assign w_store_wen  = w_any_wen && !w_rd_zero;
    assign w_store_data = w_rd_zero ? '0 : w_merge_data;

    assign w_out_valid = (r_count != 2'd0);
    assign w_in_ready  = (r_count < 2'd2);
    assign w_accept    = bus.in_valid_i && w_in_ready && !bus.flush_i;
    assign w_pop       = w_out_valid && bus.out_ready_i;
    assign w_tail      = r_head ^ r_count[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 2'd0;
            r_head  <= 1'b0;
            r_multi <= 1'b0;
        end else if (bus.flush_i) begin
            r_count <= 2'd0;
            r_head  <= 1'b0;
        end else begin
            r_count <= r_count + {1'b0, w_accept} - {1'b0, w_pop};
            if (w_pop) begin
                r_head <= ~r_head;
            end
            if (w_accept && w_multi) begin
                r_multi <= 1'b1;
            end
        end
    end

    // Payload storage needs no reset: it is only observable through a valid count.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pc[w_tail]    <= bus.pc_i;
            r_rd[w_tail]    <= bus.rd_i;
            r_wen[w_tail]   <= w_store_wen;
            r_wdata[w_tail] <= w_store_data;
        end
    end

    assign bus.in_ready_o  = w_in_ready;
    assign bus.out_valid_o = w_out_valid;
    assign bus.pc_o        = w_out_valid ? r_pc[r_head]    : '0;
    assign bus.rd_o        = w_out_valid ? r_rd[r_head]    : '0;
    assign bus.rd_wen_o    = w_out_valid ? r_wen[r_head]   : 1'b0;
    assign bus.rd_wdata_o  = w_out_valid ? r_wdata[r_head] : '0;
    assign bus.multi_src_o = r_multi;

`ifdef WB_FWD_EN
    logic [1:0] w_match;
    logic       w_young;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic w_entry_valid;
            assign w_entry_valid = (r_count == 2'd2) || ((r_count == 2'd1) && (r_head == 1'(gi)));
            assign w_match[gi]   = w_entry_valid && r_wen[gi] &&
                                   (r_rd[gi] == bus.fwd_rs_i) && (bus.fwd_rs_i != '0);
        end
    endgenerate

    // With two entries the slot after the head is the younger one.
    assign w_young        = ~r_head;
    assign bus.fwd_hit_o  = |w_match;
    assign bus.fwd_data_o = w_match[w_young] ? r_wdata[w_young] :
                            w_match[r_head]  ? r_wdata[r_head]  : '0;
`else
    logic w_fwd_unused;
    assign w_fwd_unused   = ^bus.fwd_rs_i;
    assign bus.fwd_hit_o  = 1'b0;
    assign bus.fwd_data_o = '0;
`endif

endmodule
